// File: rtl/mini_alu_core_pkg.sv
// Shared definitions for mini_alu_core: opcode encoding, FSM states and
// instruction-width derivation.
package mini_alu_core_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_LED  = 4'd7,
        OP_BLE  = 4'd8,
        OP_JMP  = 4'd9,
        OP_CALL = 4'd10,
        OP_RET  = 4'd11,
        OP_STO  = 4'd12,
        OP_OUT  = 4'd13,
        OP_RSVD = 4'd14,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Instruction word is {op[3:0], dest, src1, src0}.
    function automatic int calc_iw(input int reg_aw);
        return 4 + 3 * reg_aw;
    endfunction

endpackage

// File: rtl/mini_alu_core_call_stack.sv
// LIFO of return addresses; full/empty flags guard overflow and underflow.
module mini_alu_core_call_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iPush,
    input  logic         iPop,
    input  logic [W-1:0] iData,
    output logic [W-1:0] oTop,
    output logic         oFull,
    output logic         oEmpty
);
    localparam int IX_W = $clog2(DEPTH);
    localparam int SP_W = IX_W + 1;

    logic [SP_W-1:0] sp_q, sp_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [IX_W-1:0] top_ix;

    assign oFull  = (sp_q == SP_W'(DEPTH));
    assign oEmpty = (sp_q == '0);
    assign top_ix = IX_W'(sp_q - SP_W'(1));
    assign oTop   = mem_q[top_ix];

    always_comb begin
        sp_d = sp_q;
        if (iPush && !oFull) begin
            sp_d = sp_q + SP_W'(1);
        end else if (iPop && !oEmpty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage is not reset; only entries below sp are ever read.
    always_ff @(posedge Clock) begin
        if (!Reset && iPush && !oFull) begin
            mem_q[sp_q[IX_W-1:0]] <= iData;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage core: fetch/decode latches the ROM word, execute runs it against
// the register file, call stack and the valid/ready peripheral port.
module mini_alu_core
    import mini_alu_core_pkg::*;
#(
    parameter  int DATA_W      = 16,
    parameter  int REG_AW      = 8,
    parameter  int IP_W        = 16,
    parameter  int STACK_DEPTH = 4,
    localparam int IW          = calc_iw(REG_AW)
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [IP_W-1:0]   oIP,
    input  logic [IW-1:0]     iInstruction,
    output logic [7:0]        oLed,
    output logic              oOutValid,
    output logic [REG_AW-1:0] oOutAddr,
    output logic [DATA_W-1:0] oOutData,
    input  logic              iOutReady,
    output logic              oHalted,
    output logic              oFault,
    output state_e            oDbgState
);
    logic [IP_W-1:0]   ip_q, ip_d;
    logic [IW-1:0]     ex_q, ex_d;
    state_e            state_q, state_d;
    logic [7:0]        led_q, led_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] regs_q [2**REG_AW];

    op_e               ex_op;
    logic [REG_AW-1:0] ex_dst, ex_s1, ex_s0;
    logic [DATA_W-1:0] rs1, rs0;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              push, pop, stk_full, stk_empty;
    logic [IP_W-1:0]   stk_top;
    logic              br_taken, halt_now, stall, out_valid;
    logic [IP_W-1:0]   br_target, fetch_ip;

    assign ex_op  = op_e'(ex_q[IW-1 -: 4]);
    assign ex_dst = ex_q[3*REG_AW-1 -: REG_AW];
    assign ex_s1  = ex_q[2*REG_AW-1 -: REG_AW];
    assign ex_s0  = ex_q[REG_AW-1:0];
    assign rs1    = regs_q[ex_s1];
    assign rs0    = regs_q[ex_s0];

    mini_alu_core_call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (IP_W)
    ) u_call_stack (
        .Clock  (Clock),
        .Reset  (Reset),
        .iPush  (push),
        .iPop   (pop),
        .iData  (ip_q),
        .oTop   (stk_top),
        .oFull  (stk_full),
        .oEmpty (stk_empty)
    );

    // Peripheral port: a transfer happens on any cycle where oOutValid and
    // iOutReady are both high; once raised, oOutValid and its payload stay
    // stable until that cycle, and no other instruction executes meanwhile.
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        ex_d      = ex_q;
        led_d     = led_q;
        fault_d   = fault_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        push      = 1'b0;
        pop       = 1'b0;
        br_taken  = 1'b0;
        br_target = IP_W'(ex_dst);
        halt_now  = 1'b0;
        stall     = 1'b0;
        out_valid = 1'b0;
        fetch_ip  = ip_q;

        if (state_q != ST_HALTED) begin
            case (ex_op)
                OP_ADD: begin wr_en = 1'b1; wr_data = rs1 + rs0; end
                OP_SUB: begin wr_en = 1'b1; wr_data = rs1 - rs0; end
                OP_AND: begin wr_en = 1'b1; wr_data = rs1 & rs0; end
                OP_OR:  begin wr_en = 1'b1; wr_data = rs1 | rs0; end
                OP_SHL: begin wr_en = 1'b1; wr_data = rs1 << rs0[3:0]; end
                OP_SHR: begin wr_en = 1'b1; wr_data = rs1 >> rs0[3:0]; end
                OP_LED: led_d = rs1[7:0];
                OP_BLE: br_taken = (rs1 <= rs0);
                OP_JMP: br_taken = 1'b1;
                OP_CALL: begin
                    if (stk_full) begin
                        halt_now = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        push     = 1'b1;
                        br_taken = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        halt_now = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        pop       = 1'b1;
                        br_taken  = 1'b1;
                        br_target = stk_top;
                    end
                end
                OP_STO: begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'(ex_q[2*REG_AW-1:0]);
                end
                OP_OUT: begin
                    out_valid = 1'b1;
                    stall     = !iOutReady;
                end
                OP_HALT: halt_now = 1'b1;
                default: ;
            endcase

            if (br_taken) begin
                fetch_ip = br_target;
            end

            // A halting or faulting instruction freezes ip and drops the fetch.
            if (halt_now) begin
                state_d = ST_HALTED;
            end else if (stall) begin
                state_d = ST_WAIT;
            end else begin
                state_d = ST_RUN;
                ex_d    = iInstruction;
                ip_d    = fetch_ip + IP_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_RUN;
            ip_q    <= '0;
            ex_q    <= {OP_NOP, {(3*REG_AW){1'b0}}};
            led_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            ex_q    <= ex_d;
            led_q   <= led_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && wr_en) begin
            regs_q[ex_dst] <= wr_data;
        end
    end

    assign oIP       = fetch_ip;
    assign oLed      = led_q;
    assign oOutValid = out_valid;
    assign oOutAddr  = rs0[REG_AW-1:0];
    assign oOutData  = rs1;
    assign oHalted   = (state_q == ST_HALTED);
    assign oFault    = fault_q;
    assign oDbgState = state_q;

endmodule
